// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for mem_bus_arbiter: bus state machine states and bus owner.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUED = 2'd1,
    WAIT   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_req_slot.sv
// One requester slot: captures a strobed request, reports busy, and holds returned read data.
module arb_req_slot #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  input  logic                    wstrb,
  input  logic                    rstrb,
  input  logic                    clear,
  input  logic                    load_rdata,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  output logic                    req,
  output logic                    req_write,
  output logic [ADDR_WIDTH-1:0]   req_addr,
  output logic [DATA_WIDTH-1:0]   req_wdata,
  output logic [DATA_WIDTH/8-1:0] req_wmask,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic                    pending;
  logic                    pend_write;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wmask_q;
  logic                    strobe;
  logic                    capture;

  assign strobe  = wstrb | rstrb;
  // A strobe landing on the completion cycle starts a fresh request.
  assign capture = strobe & (~pending | clear);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= 1'b0;
      pend_write <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata      <= '0;
    end else begin
      if (capture) begin
        pending    <= 1'b1;
        pend_write <= wstrb;
        addr_q     <= addr;
        wdata_q    <= wdata;
        wmask_q    <= wmask;
      end else if (clear) begin
        pending    <= 1'b0;
      end
      if (load_rdata) rdata <= bus_rdata;
    end
  end

  // The arbiter may grant in the strobe cycle itself, so expose live inputs until latched.
  assign req       = pending | strobe;
  assign req_write = pending ? pend_write : wstrb;
  assign req_addr  = pending ? addr_q  : addr;
  assign req_wdata = pending ? wdata_q : wdata;
  assign req_wmask = pending ? wmask_q : wmask;
  assign busy      = pending | strobe;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch (i) and data (d) ports of the core.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants when both ports are pending.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic                    i_rstrb,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_rbusy,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  input  logic                    d_wstrb,
  input  logic                    d_rstrb,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_rbusy,
  output logic                    d_wbusy,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_wmask,
  output logic                    bus_wstrb,
  output logic                    bus_rstrb,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  input  logic                    bus_busy
);

  localparam int MW = DATA_WIDTH / 8;

  state_t state;
  owner_t owner;
  logic   owner_write;
  logic   done, i_clear, d_clear, grant_d;

  logic                  i_req, i_req_write, i_busy;
  logic                  d_req, d_req_write, d_busy;
  logic [ADDR_WIDTH-1:0] i_req_addr, d_req_addr, w_addr;
  logic [DATA_WIDTH-1:0] i_req_wdata, d_req_wdata, w_wdata;
  logic [MW-1:0]         i_req_wmask, d_req_wmask, w_wmask;
  logic                  w_write;

  assign done    = (state == WAIT) && !bus_busy;
  assign i_clear = done && (owner == OWN_I);
  assign d_clear = done && (owner == OWN_D);

  arb_req_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_i_slot (
    .clk(clk), .rst(rst),
    .addr(i_addr), .wdata('0), .wmask('0), .wstrb(1'b0), .rstrb(i_rstrb),
    .clear(i_clear), .load_rdata(i_clear), .bus_rdata(bus_rdata),
    .req(i_req), .req_write(i_req_write), .req_addr(i_req_addr),
    .req_wdata(i_req_wdata), .req_wmask(i_req_wmask),
    .busy(i_busy), .rdata(i_rdata)
  );

  arb_req_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_d_slot (
    .clk(clk), .rst(rst),
    .addr(d_addr), .wdata(d_wdata), .wmask(d_wmask), .wstrb(d_wstrb), .rstrb(d_rstrb),
    .clear(d_clear), .load_rdata(d_clear && !owner_write), .bus_rdata(bus_rdata),
    .req(d_req), .req_write(d_req_write), .req_addr(d_req_addr),
    .req_wdata(d_req_wdata), .req_wmask(d_req_wmask),
    .busy(d_busy), .rdata(d_rdata)
  );

  assign i_rbusy = i_busy & ~i_req_write;
  assign d_wbusy = d_busy & d_req_write;
  assign d_rbusy = d_busy & ~d_req_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t last_grant;

  always_comb begin
    grant_d = d_req;
    if (i_req && d_req) grant_d = (last_grant == OWN_I);
  end
`else
  assign grant_d = d_req;
`endif

  assign w_write = grant_d ? d_req_write : i_req_write;
  assign w_addr  = grant_d ? d_req_addr  : i_req_addr;
  assign w_wdata = grant_d ? d_req_wdata : i_req_wdata;
  assign w_wmask = grant_d ? d_req_wmask : i_req_wmask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_I;
      owner_write <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_wmask   <= '0;
      bus_wstrb   <= 1'b0;
      bus_rstrb   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant  <= OWN_I;
`endif
    end else begin
      bus_wstrb <= 1'b0;
      bus_rstrb <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner       <= grant_d ? OWN_D : OWN_I;
            owner_write <= w_write;
            bus_addr    <= w_addr;
            bus_wdata   <= w_wdata;
            bus_wmask   <= w_write ? w_wmask : '0;
            bus_wstrb   <= w_write;
            bus_rstrb   <= ~w_write;
            state       <= ISSUED;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant  <= grant_d ? OWN_D : OWN_I;
`endif
          end
        end
        ISSUED: state <= WAIT;
        WAIT:   if (!bus_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a cycle-level request/bus model and literal pins.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_rstrb, d_wstrb, d_rstrb;
  logic [3:0]  d_wmask;
  logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata, bus_rdata;
  logic        i_rbusy, d_rbusy, d_wbusy;
  logic [3:0]  bus_wmask;
  logic        bus_wstrb, bus_rstrb, bus_busy;

  logic tgt_busy = 1'b0;
  logic force_busy = 1'b0;
  int   wait_cfg = 0;
  int   rem = 0;
  int   cyc = 0;
  int   n_strobes = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_rstrb(i_rstrb), .i_rdata(i_rdata), .i_rbusy(i_rbusy),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask), .d_wstrb(d_wstrb),
    .d_rstrb(d_rstrb), .d_rdata(d_rdata), .d_rbusy(d_rbusy), .d_wbusy(d_wbusy),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_wstrb(bus_wstrb), .bus_rstrb(bus_rstrb), .bus_rdata(bus_rdata),
    .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : {a[15:0], 16'hC0DE};
  endfunction

  assign bus_rdata = rd_fn(bus_addr);
  assign bus_busy  = tgt_busy | force_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Target: after seeing a bus strobe, holds busy for wait_cfg cycles, then completes.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst) begin
      rem = 0;
      tgt_busy = 1'b0;
    end else begin
      if (rem > 0) begin
        tgt_busy = 1'b1;
        rem--;
      end else begin
        tgt_busy = 1'b0;
      end
      if (bus_rstrb || bus_wstrb) rem = wait_cfg;
    end
  end

  always @(negedge clk) if (!rst && (bus_rstrb || bus_wstrb)) n_strobes++;

  // Reference model: index 0 = fetch port, 1 = data port.
  logic        m_pend [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_rdata [2];
  logic        m_wr_d;
  logic [31:0] m_wdata_d;
  logic [3:0]  m_wmask_d;
  logic        m_bus_on, m_own_wr;
  int          m_own, m_issue_cyc, m_last;
  logic [31:0] m_bus_addr, m_bus_wdata;
  logic [3:0]  m_bus_wmask;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_addr[k] = 0; m_rdata[k] = 0;
    end
    m_wr_d = 0; m_wdata_d = 0; m_wmask_d = 0;
    m_bus_on = 0; m_own_wr = 0; m_own = 0; m_issue_cyc = -10; m_last = 0;
    m_bus_addr = 0; m_bus_wdata = 0; m_bus_wmask = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      logic d_str, d_eff_wr, was_on, req_i, req_d, done_i, done_d;
      int   win;
      d_str    = d_wstrb | d_rstrb;
      d_eff_wr = m_pend[1] ? m_wr_d : d_wstrb;
      chk("i_rbusy", {31'd0, i_rbusy}, {31'd0, i_rstrb | m_pend[0]});
      chk("d_wbusy", {31'd0, d_wbusy}, {31'd0, (d_str | m_pend[1]) & d_eff_wr});
      chk("d_rbusy", {31'd0, d_rbusy}, {31'd0, (d_str | m_pend[1]) & ~d_eff_wr});
      chk("bus_rstrb", {31'd0, bus_rstrb},
          {31'd0, m_bus_on && m_issue_cyc == cyc && !m_own_wr});
      chk("bus_wstrb", {31'd0, bus_wstrb},
          {31'd0, m_bus_on && m_issue_cyc == cyc && m_own_wr});
      chk("bus_addr", bus_addr, m_bus_addr);
      chk("bus_wmask", {28'd0, bus_wmask}, {28'd0, m_bus_wmask});
      if (m_own_wr) chk("bus_wdata", bus_wdata, m_bus_wdata);
      chk("i_rdata", i_rdata, m_rdata[0]);
      chk("d_rdata", d_rdata, m_rdata[1]);

      was_on = m_bus_on;
      done_i = 0;
      done_d = 0;
      if (m_bus_on && cyc > m_issue_cyc && !bus_busy) begin
        if (!m_own_wr) m_rdata[m_own] = rd_fn(m_bus_addr);
        if (m_own == 1) done_d = 1; else done_i = 1;
        m_pend[m_own] = 0;
        m_bus_on = 0;
      end
      if (!was_on) begin
        req_i = m_pend[0] | i_rstrb;
        req_d = m_pend[1] | d_str;
        if (req_i || req_d) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          win = (req_i && req_d) ? (m_last == 1 ? 0 : 1) : (req_d ? 1 : 0);
`else
          win = req_d ? 1 : 0;
`endif
          m_own = win;
          m_last = win;
          m_bus_on = 1;
          m_issue_cyc = cyc + 1;
          if (win == 1) begin
            m_own_wr    = d_eff_wr;
            m_bus_addr  = m_pend[1] ? m_addr[1] : d_addr;
            m_bus_wdata = m_pend[1] ? m_wdata_d : d_wdata;
            m_bus_wmask = d_eff_wr ? (m_pend[1] ? m_wmask_d : d_wmask) : 4'd0;
          end else begin
            m_own_wr    = 0;
            m_bus_addr  = m_pend[0] ? m_addr[0] : i_addr;
            m_bus_wmask = 4'd0;
          end
        end
      end
      if (i_rstrb && (!m_pend[0] || done_i)) begin
        m_pend[0] = 1; m_addr[0] = i_addr;
      end
      if (d_str && (!m_pend[1] || done_d)) begin
        m_pend[1] = 1; m_addr[1] = d_addr; m_wr_d = d_wstrb;
        m_wdata_d = d_wdata; m_wmask_d = d_wmask;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    rst = 1'b1;
    i_addr = 0; i_rstrb = 0; d_addr = 0; d_wdata = 0; d_wmask = 0;
    d_wstrb = 0; d_rstrb = 0;
    repeat (2) tick();
    chk("rst_i_rbusy", {31'd0, i_rbusy}, 32'd0);
    chk("rst_d_busy", {30'd0, d_rbusy, d_wbusy}, 32'd0);
    chk("rst_bus_strb", {30'd0, bus_rstrb, bus_wstrb}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // Single fetch, zero-wait target
    i_addr = 32'h100; i_rstrb = 1;
    tick();
    chk("f1_rstrb", {31'd0, bus_rstrb}, 32'd1);
    chk("f1_addr", bus_addr, 32'h100);
    chk("f1_busy_t1", {31'd0, i_rbusy}, 32'd1);
    i_rstrb = 0;
    tick();
    chk("f1_busy_t2", {31'd0, i_rbusy}, 32'd1);
    tick();
    chk("f1_busy_t3", {31'd0, i_rbusy}, 32'd0);
    chk("f1_rdata", i_rdata, 32'h13);
    repeat (3) tick();

    // Store with three wait states
    wait_cfg = 3;
    d_addr = 32'h2004; d_wdata = 32'hAABBCCDD; d_wmask = 4'b0100; d_wstrb = 1;
    tick();
    chk("st_wstrb", {31'd0, bus_wstrb}, 32'd1);
    chk("st_mask", {28'd0, bus_wmask}, 32'h4);
    chk("st_addr", bus_addr, 32'h2004);
    chk("st_wdata", bus_wdata, 32'hAABBCCDD);
    d_wstrb = 0;
    tick();
    chk("st_wstrb_once", {31'd0, bus_wstrb}, 32'd0);
    repeat (3) tick();
    chk("st_wbusy_t5", {31'd0, d_wbusy}, 32'd1);
    tick();
    chk("st_wbusy_t6", {31'd0, d_wbusy}, 32'd0);
    chk("st_drdata", d_rdata, 32'd0);
    wait_cfg = 0;
    repeat (3) tick();

    // Simultaneous fetch and load
    i_addr = 32'h300; d_addr = 32'h400; i_rstrb = 1; d_rstrb = 1;
    tick();
    i_rstrb = 0; d_rstrb = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("sim_first", bus_addr, 32'h300);
`else
    chk("sim_first", bus_addr, 32'h400);
`endif
    chk("sim_first_rs", {31'd0, bus_rstrb}, 32'd1);
    repeat (3) tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("sim_second", bus_addr, 32'h400);
`else
    chk("sim_second", bus_addr, 32'h300);
`endif
    chk("sim_second_rs", {31'd0, bus_rstrb}, 32'd1);
    repeat (3) tick();
    chk("sim_irdata", i_rdata, 32'h0300C0DE);
    chk("sim_drdata", d_rdata, 32'h0400C0DE);

    // Fetch arrives while the load is waiting
    wait_cfg = 2;
    s0 = n_strobes;
    d_addr = 32'h500; d_rstrb = 1;
    tick();
    d_rstrb = 0;
    tick();
    i_addr = 32'h600; i_rstrb = 1;
    tick();
    i_rstrb = 0;
    chk("b2b_ibusy", {31'd0, i_rbusy}, 32'd1);
    repeat (3) tick();
    chk("b2b_i_rs", {31'd0, bus_rstrb}, 32'd1);
    chk("b2b_i_addr", bus_addr, 32'h600);
    wait_cfg = 0;
    repeat (6) tick();
    chk("b2b_count", n_strobes - s0, 32'd2);
    chk("b2b_drdata", d_rdata, 32'h0500C0DE);
    chk("b2b_irdata", i_rdata, 32'h0600C0DE);

    // Reset while the target is still busy
    force_busy = 1;
    i_addr = 32'h700; i_rstrb = 1;
    tick();
    i_rstrb = 0;
    repeat (2) tick();
    rst = 1;
    #1;
    chk("mr_busy", {29'd0, i_rbusy, d_rbusy, d_wbusy}, 32'd0);
    chk("mr_strb", {30'd0, bus_rstrb, bus_wstrb}, 32'd0);
    chk("mr_addr", bus_addr, 32'd0);
    chk("mr_irdata", i_rdata, 32'd0);
    chk("mr_drdata", d_rdata, 32'd0);
    tick();
    rst = 0;
    tick();
    s0 = n_strobes;
    force_busy = 0;
    repeat (4) tick();
    chk("mr_late_irdata", i_rdata, 32'd0);
    chk("mr_late_busy", {31'd0, i_rbusy}, 32'd0);
    chk("mr_late_strobes", n_strobes - s0, 32'd0);

    // Re-strobe while busy is ignored
    s0 = n_strobes;
    i_addr = 32'h100; i_rstrb = 1;
    tick();
    i_addr = 32'h200; i_rstrb = 1;
    chk("rs_addr_t1", bus_addr, 32'h100);
    tick();
    i_rstrb = 0;
    chk("rs_addr_t2", bus_addr, 32'h100);
    chk("rs_no_restrobe", {31'd0, bus_rstrb}, 32'd0);
    tick();
    chk("rs_busy_t3", {31'd0, i_rbusy}, 32'd0);
    chk("rs_rdata", i_rdata, 32'h13);
    repeat (4) tick();
    chk("rs_count", n_strobes - s0, 32'd1);
    chk("rs_addr_end", bus_addr, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
